// File: rtl/instruction_fetch_if.sv
// Instruction-memory request bus between the fetch stage (master) and the IM (slave).
interface instruction_fetch_if #(
    parameter int PC_WIDTH = 32
);
    logic                IM_enable;
    logic [PC_WIDTH-1:0] IM_address;
    logic                IM_ready;
    logic [31:0]         IM_rdata;

    modport master (
        output IM_enable,
        output IM_address,
        input  IM_ready,
        input  IM_rdata
    );

    modport slave (
        input  IM_enable,
        input  IM_address,
        output IM_ready,
        output IM_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues IM requests, waits for a variable-latency
// response with a timeout, and latches the returned word into ir.
module instruction_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset,
    instruction_fetch_if.master im,
    input  logic                fetch_start,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         ir,
    output logic                ir_valid,
    output logic                fetch_busy,
    output logic                fetch_error
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic                error_q, error_d;
    logic                pend_valid_q, pend_valid_d;
    logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PC_WIDTH-1:0] target_aligned;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;

    // A redirect arriving in the same cycle as DONE or a timeout beats the stored one.
    assign target_aligned = pc_target & ~PC_WIDTH'(3);
    assign redirect       = pc_load | pend_valid_q;
    assign redirect_pc    = pc_load ? target_aligned : pend_target_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        error_d       = error_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        cnt_d         = cnt_q;

        if (pc_load && (state_q != ST_IDLE)) begin
            pend_valid_d  = 1'b1;
            pend_target_d = target_aligned;
        end

        case (state_q)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_d = target_aligned;
                end
                if (fetch_start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (im.IM_ready) begin
                    ir_d    = im.IM_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    error_d      = 1'b1;
                    state_d      = ST_IDLE;
                    pend_valid_d = 1'b0;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                pend_valid_d = 1'b0;
                pc_d         = redirect ? redirect_pc : pc_q + PC_WIDTH'(4);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            error_q       <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            error_q       <= error_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            cnt_q         <= cnt_d;
        end
    end

    assign im.IM_enable  = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign im.IM_address = pc_q;
    assign pc            = pc_q;
    assign ir            = ir_q;
    assign ir_valid      = (state_q == ST_DONE);
    assign fetch_busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign fetch_error   = error_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: basic fetch, wait states, timeout,
// redirects, PC wrap, ignored fetch_start and asynchronous reset mid-fetch.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_busy;
    logic        fetch_error;

    int vectors;
    int miscompares;

    instruction_fetch_if #(.PC_WIDTH(32)) im_bus ();

    instruction_fetch #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .im         (im_bus.master),
        .fetch_start(fetch_start),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .pc         (pc),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .fetch_error(fetch_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one fetch and leaves the bench in DONE (success) or IDLE (timeout).
    task automatic applyStimulus(
        input  int          delay,
        input  logic [31:0] data,
        input  logic        start_load,
        input  logic [31:0] start_target,
        input  logic        mid_load,
        input  logic [31:0] mid_target,
        input  logic        noise,
        output int          lat,
        output logic [31:0] req_addr,
        output logic        en_ok
    );
        int k;
        fetch_start = 1'b1;
        pc_load     = start_load;
        pc_target   = start_target;
        tick();
        fetch_start       = 1'b0;
        pc_load           = 1'b0;
        req_addr          = im_bus.IM_address;
        en_ok             = im_bus.IM_enable;
        lat               = 1;
        im_bus.IM_rdata   = data;
        im_bus.IM_ready   = 1'b0;
        tick();
        lat = 2;
        k   = 0;
        while (!ir_valid && fetch_busy && lat < 60) begin
            en_ok           = en_ok & im_bus.IM_enable;
            im_bus.IM_ready = (k >= delay);
            fetch_start     = noise;
            pc_load         = mid_load && (k < 2);
            pc_target       = (k == 0) ? (mid_target ^ 32'h0000_0100) : mid_target;
            tick();
            lat++;
            k++;
        end
        im_bus.IM_ready = 1'b0;
        fetch_start     = 1'b0;
        pc_load         = 1'b0;
    endtask

    int          lat;
    logic [31:0] req_addr;
    logic        en_ok;

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b0;
        fetch_start     = 1'b0;
        pc_load         = 1'b0;
        pc_target       = '0;
        im_bus.IM_ready = 1'b0;
        im_bus.IM_rdata = '0;
        #1;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_ir", ir, 32'h0);
        checkOutput("reset_ir_valid", {31'b0, ir_valid}, 32'h0);
        checkOutput("reset_enable", {31'b0, im_bus.IM_enable}, 32'h0);
        checkOutput("reset_busy", {31'b0, fetch_busy}, 32'h0);
        checkOutput("reset_error", {31'b0, fetch_error}, 32'h0);
        tick();
        tick();
        #4 reset = 1'b1;

        // Basic fetch, ready on first WAIT cycle
        applyStimulus(0, 32'h0A10_8000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lat, req_addr, en_ok);
        checkOutput("basic_req_addr", req_addr, 32'h0);
        checkOutput("basic_req_en", {31'b0, en_ok}, 32'h1);
        checkOutput("basic_latency", lat, 3);
        checkOutput("basic_ir", ir, 32'h0A10_8000);
        tick();
        checkOutput("basic_pc", pc, 32'h4);
        checkOutput("basic_valid_pulse", {31'b0, ir_valid}, 32'h0);

        // Five wait states
        applyStimulus(5, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lat, req_addr, en_ok);
        checkOutput("wait_latency", lat, 8);
        checkOutput("wait_enable_held", {31'b0, en_ok}, 32'h1);
        checkOutput("wait_ir", ir, 32'h1122_3344);
        checkOutput("wait_error", {31'b0, fetch_error}, 32'h0);
        tick();
        checkOutput("wait_pc", pc, 32'h8);

        // Timeout: IM never responds
        applyStimulus(100, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lat, req_addr, en_ok);
        checkOutput("timeout_latency", lat, 17);
        checkOutput("timeout_error", {31'b0, fetch_error}, 32'h1);
        checkOutput("timeout_ir", ir, 32'h1122_3344);
        checkOutput("timeout_pc", pc, 32'h8);
        checkOutput("timeout_busy", {31'b0, fetch_busy}, 32'h0);

        // Fetch after timeout still works; error stays sticky
        applyStimulus(1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lat, req_addr, en_ok);
        checkOutput("after_to_latency", lat, 4);
        checkOutput("after_to_ir", ir, 32'hCAFE_F00D);
        checkOutput("after_to_error", {31'b0, fetch_error}, 32'h1);
        tick();
        checkOutput("after_to_pc", pc, 32'hC);

        // Redirect in IDLE together with fetch_start
        applyStimulus(0, 32'h0000_0001, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0, lat, req_addr, en_ok);
        checkOutput("idle_load_addr", req_addr, 32'h0000_0100);
        tick();
        checkOutput("idle_load_pc", pc, 32'h0000_0104);

        // Redirect during WAIT, second load overwrites the first
        applyStimulus(3, 32'h0000_0002, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0, lat, req_addr, en_ok);
        checkOutput("wait_load_latency", lat, 6);
        checkOutput("wait_load_req_addr", req_addr, 32'h0000_0104);
        tick();
        checkOutput("wait_load_pc", pc, 32'h0000_0200);

        // PC wrap from the top of the address space
        applyStimulus(0, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, lat, req_addr, en_ok);
        checkOutput("wrap_req_addr", req_addr, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_pc", pc, 32'h0);

        // fetch_start pulses during WAIT are ignored
        applyStimulus(3, 32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, lat, req_addr, en_ok);
        checkOutput("noise_latency", lat, 6);
        tick();
        checkOutput("noise_pc", pc, 32'h4);
        checkOutput("noise_busy_1", {31'b0, fetch_busy}, 32'h0);
        tick();
        checkOutput("noise_busy_2", {31'b0, fetch_busy}, 32'h0);
        checkOutput("noise_pc_hold", pc, 32'h4);

        // Pending redirect applied on timeout
        applyStimulus(100, 32'h0000_0005, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, lat, req_addr, en_ok);
        checkOutput("to_redirect_latency", lat, 17);
        checkOutput("to_redirect_pc", pc, 32'h0000_0040);
        checkOutput("to_redirect_ir", ir, 32'h0000_0004);

        // Asynchronous reset while in WAIT
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        checkOutput("pre_reset_busy", {31'b0, fetch_busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_pc", pc, 32'h0);
        checkOutput("async_ir", ir, 32'h0);
        checkOutput("async_enable", {31'b0, im_bus.IM_enable}, 32'h0);
        checkOutput("async_busy", {31'b0, fetch_busy}, 32'h0);
        checkOutput("async_error", {31'b0, fetch_error}, 32'h0);
        #2 reset = 1'b1;
        im_bus.IM_rdata = 32'hBADB_ADBA;
        im_bus.IM_ready = 1'b1;
        tick();
        tick();
        checkOutput("post_reset_ir", ir, 32'h0);
        checkOutput("post_reset_valid", {31'b0, ir_valid}, 32'h0);
        checkOutput("post_reset_busy", {31'b0, fetch_busy}, 32'h0);
        im_bus.IM_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
